// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: memory-side responder for a 256-bit cache-line port.
// Each line read or write is split into eight 32-bit beats on a word-wide
// synchronous RAM. Completion is a single-cycle mem_ack_o pulse.
//
// Optional feature macro: LMC_LINE_BUFFER_EN
//   When defined, a valid bit and tag (addr[31:5]) track the line register so
//   repeated reads of the same line are acked without touching the RAM.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mem_addr_i          line byte address (bits [4:0] ignored)
//   mem_data_i/_o       write line in / read line out (word k = bits [32k+31:32k])
//   mem_rd_i, mem_we_i  line read / write requests, held until ack
//   mem_ack_o           one-cycle completion pulse
//   ram_addr_o          word address {line address, beat}
//   ram_data_o/_i       write word out / read word in
//   ram_en_o, ram_we_o  beat strobe and write qualifier
module line_mem_ctrl #(
   parameter int unsigned RAM_LATENCY = 1,
   parameter int unsigned RAM_AW      = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       mem_addr_i,
   input  logic [255:0]      mem_data_i,
   output logic [255:0]      mem_data_o,
   input  logic              mem_rd_i,
   input  logic              mem_we_i,
   output logic              mem_ack_o,
   output logic [RAM_AW-1:0] ram_addr_o,
   output logic [31:0]       ram_data_o,
   input  logic [31:0]       ram_data_i,
   output logic              ram_en_o,
   output logic              ram_we_o
);

   localparam int unsigned LINE_AW = RAM_AW - 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_ACK   = 2'd3;

   logic [1:0]             state_q, state_d;
   logic [2:0]             issue_cnt_q, issue_cnt_d;
   logic [2:0]             ret_cnt_q, ret_cnt_d;
   logic                   issue_done_q, issue_done_d;
   logic [RAM_LATENCY-1:0] pipe_q, pipe_d;
   logic [LINE_AW-1:0]     addr_q, addr_d;
   logic [255:0]           wline_q, wline_d;
   logic [255:0]           line_q, line_d;

   logic rd_issue;
   logic wr_issue;
   logic capture;

`ifdef LMC_LINE_BUFFER_EN
   logic        valid_q, valid_d;
   logic [26:0] tag_q, tag_d;
   logic        tag_match;
   assign tag_match = valid_q && (tag_q == mem_addr_i[31:5]);
`endif

   // Only a slice of the byte address reaches the RAM in the default build.
   logic unused_addr;
   assign unused_addr = ^mem_addr_i;

   // A token per issued read beat, aged until its data is valid on ram_data_i.
   assign capture = (state_q == ST_READ) && pipe_q[RAM_LATENCY-1];
   assign pipe_d  = RAM_LATENCY'({pipe_q, rd_issue});

   always_comb begin
      state_d      = state_q;
      issue_cnt_d  = issue_cnt_q;
      ret_cnt_d    = ret_cnt_q;
      issue_done_d = issue_done_q;
      addr_d       = addr_q;
      wline_d      = wline_q;
      line_d       = line_q;
      rd_issue     = 1'b0;
      wr_issue     = 1'b0;
`ifdef LMC_LINE_BUFFER_EN
      valid_d      = valid_q;
      tag_d        = tag_q;
`endif
      case (state_q)
         ST_IDLE: begin
            issue_cnt_d  = 3'd0;
            ret_cnt_d    = 3'd0;
            issue_done_d = 1'b0;
            if (mem_we_i) begin
               state_d = ST_WRITE;
               addr_d  = mem_addr_i[RAM_AW+1:5];
               wline_d = mem_data_i;
`ifdef LMC_LINE_BUFFER_EN
               // Write-through keeps the buffered line coherent.
               if (tag_match) line_d = mem_data_i;
`endif
            end else if (mem_rd_i) begin
               addr_d  = mem_addr_i[RAM_AW+1:5];
`ifdef LMC_LINE_BUFFER_EN
               if (tag_match) begin
                  state_d = ST_ACK;
               end else begin
                  state_d = ST_READ;
                  tag_d   = mem_addr_i[31:5];
                  valid_d = 1'b0;
               end
`else
               state_d = ST_READ;
`endif
            end
         end
         ST_READ: begin
            if (!issue_done_q) begin
               rd_issue    = 1'b1;
               issue_cnt_d = issue_cnt_q + 3'd1;
               if (issue_cnt_q == 3'd7) issue_done_d = 1'b1;
            end
            if (capture) begin
               line_d[{ret_cnt_q, 5'd0} +: 32] = ram_data_i;
               ret_cnt_d = ret_cnt_q + 3'd1;
               if (ret_cnt_q == 3'd7) begin
                  state_d = ST_ACK;
`ifdef LMC_LINE_BUFFER_EN
                  valid_d = 1'b1;
`endif
               end
            end
         end
         ST_WRITE: begin
            wr_issue    = 1'b1;
            issue_cnt_d = issue_cnt_q + 3'd1;
            if (issue_cnt_q == 3'd7) state_d = ST_ACK;
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         issue_cnt_q  <= 3'd0;
         ret_cnt_q    <= 3'd0;
         issue_done_q <= 1'b0;
         pipe_q       <= '0;
         addr_q       <= '0;
         wline_q      <= '0;
         line_q       <= '0;
      end else begin
         state_q      <= state_d;
         issue_cnt_q  <= issue_cnt_d;
         ret_cnt_q    <= ret_cnt_d;
         issue_done_q <= issue_done_d;
         pipe_q       <= pipe_d;
         addr_q       <= addr_d;
         wline_q      <= wline_d;
         line_q       <= line_d;
      end
   end

`ifdef LMC_LINE_BUFFER_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
      end
   end
`endif

   assign mem_ack_o  = (state_q == ST_ACK);
   assign mem_data_o = line_q;
   assign ram_en_o   = rd_issue | wr_issue;
   assign ram_we_o   = wr_issue;
   assign ram_addr_o = ram_en_o ? {addr_q, issue_cnt_q} : '0;
   assign ram_data_o = wr_issue ? wline_q[{issue_cnt_q, 5'd0} +: 32] : '0;

endmodule

// File: tb/tb_line_mem_ctrl.sv
module tb_line_mem_ctrl;

   localparam int LAT = 3;
`ifdef LMC_LINE_BUFFER_EN
   localparam bit HIT_EN = 1'b1;
`else
   localparam bit HIT_EN = 1'b0;
`endif
   localparam int RD_ACK  = 9 + LAT;
   localparam int HIT_ACK = HIT_EN ? 1 : RD_ACK;
   localparam int HIT_EN8 = HIT_EN ? 0 : 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  mem_addr_i;
   logic [255:0] mem_data_i;
   logic [255:0] mem_data_o;
   logic         mem_rd_i;
   logic         mem_we_i;
   logic         mem_ack_o;
   logic [23:0]  ram_addr_o;
   logic [31:0]  ram_data_o;
   logic [31:0]  ram_data_i;
   logic         ram_en_o;
   logic         ram_we_o;

   line_mem_ctrl #(.RAM_LATENCY(LAT), .RAM_AW(24)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .mem_addr_i (mem_addr_i),
      .mem_data_i (mem_data_i),
      .mem_data_o (mem_data_o),
      .mem_rd_i   (mem_rd_i),
      .mem_we_i   (mem_we_i),
      .mem_ack_o  (mem_ack_o),
      .ram_addr_o (ram_addr_o),
      .ram_data_o (ram_data_o),
      .ram_data_i (ram_data_i),
      .ram_en_o   (ram_en_o),
      .ram_we_o   (ram_we_o)
   );

   always #5 clk = ~clk;

   // Word-wide RAM with LAT cycles of read latency, preloaded word n = n.
   logic [31:0] ram [0:1023];
   logic [31:0] rpipe [0:LAT-1];
   bit          ram_init = 1'b0;

   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < 1024; i++) ram[i] <= 32'(i);
         ram_init <= 1'b1;
      end else if (ram_en_o && ram_we_o) begin
         ram[ram_addr_o[9:0]] <= ram_data_o;
      end
      rpipe[0] <= ram[ram_addr_o[9:0]];
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign ram_data_i = rpipe[LAT-1];

   // Transaction-level reference: memory contents plus the held line buffer.
   logic [31:0]  model_mem [0:1023];
   logic [255:0] last_line;
   bit           buf_valid;
   logic [26:0]  buf_tag;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] line_of(input logic [31:0] seed);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = seed + 32'(k);
      return l;
   endfunction

   function automatic logic [255:0] model_line(input logic [31:0] addr);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = model_mem[{addr[11:5], 3'(k)}];
      return l;
   endfunction

   function automatic bit predict_hit(input bit rd, input bit we, input logic [31:0] addr);
      return HIT_EN && rd && !we && buf_valid && (buf_tag == addr[31:5]);
   endfunction

   // Runs one request; checks every beat, the ack cycle, the returned line and RAM contents.
   task automatic do_op(input bit rd, input bit we, input logic [31:0] addr,
                        input logic [255:0] wdata, input int change_at,
                        input int exp_ack, input int exp_en);
      bit           hit;
      logic [255:0] exp_line;
      logic [31:0]  decoy;
      int           ack_cyc;
      int           en_cnt;
      logic [255:0] line_at_ack;
      hit   = predict_hit(rd, we, addr);
      decoy = addr ^ 32'h0000_03E0;
      if (we) exp_line = (HIT_EN && buf_valid && buf_tag == addr[31:5]) ? wdata : last_line;
      else if (hit) exp_line = last_line;
      else exp_line = model_line(addr);

      mem_addr_i = addr;
      mem_data_i = wdata;
      mem_rd_i   = rd;
      mem_we_i   = we;
      ack_cyc    = -1;
      en_cnt     = 0;
      line_at_ack = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ram_en_o) begin
            chk("beat_cycle", 256'(c), 256'(1 + en_cnt));
            chk("beat_we", 256'(ram_we_o), 256'(we));
            chk("beat_addr", 256'(ram_addr_o), 256'({addr[25:5], en_cnt[2:0]}));
            if (we) chk("beat_wdata", 256'(ram_data_o), 256'(wdata[32*en_cnt[2:0] +: 32]));
            en_cnt++;
         end
         if (mem_ack_o) begin
            ack_cyc     = c;
            line_at_ack = mem_data_o;
            break;
         end
         @(posedge clk);
         #1;
         if (c + 1 == change_at) begin
            mem_addr_i = decoy;
            mem_data_i = ~wdata;
         end
      end
      if (ack_cyc < 0) begin
         errors++;
         checks++;
         $display("FAIL ack_timeout: got no ack required ack in cycle %0d", exp_ack);
      end
      chk("ack_cycle", 256'(ack_cyc), 256'(exp_ack));
      chk("en_pulses", 256'(en_cnt), 256'(exp_en));
      chk("line_data", line_at_ack, exp_line);
      @(posedge clk);
      #1;
      mem_rd_i = 1'b0;
      mem_we_i = 1'b0;
      chk("ack_single", 256'(mem_ack_o), 256'(0));

      if (we) begin
         for (int k = 0; k < 8; k++) model_mem[{addr[11:5], 3'(k)}] = wdata[32*k +: 32];
         for (int k = 0; k < 8; k++)
            chk("ram_word", 256'(ram[{addr[11:5], 3'(k)}]), 256'(wdata[32*k +: 32]));
         if (change_at >= 0)
            for (int k = 0; k < 8; k++)
               chk("decoy_word", 256'(ram[{decoy[11:5], 3'(k)}]),
                   256'(model_mem[{decoy[11:5], 3'(k)}]));
      end else if (!hit) begin
         buf_valid = 1'b1;
         buf_tag   = addr[31:5];
      end
      last_line = exp_line;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_ack"},   256'(mem_ack_o),  256'(0));
      chk({tag, "_data"},  mem_data_o,       256'(0));
      chk({tag, "_en"},    256'(ram_en_o),   256'(0));
      chk({tag, "_we"},    256'(ram_we_o),   256'(0));
      chk({tag, "_addr"},  256'(ram_addr_o), 256'(0));
      chk({tag, "_wdata"}, 256'(ram_data_o), 256'(0));
   endtask

   typedef struct {
      bit          rd;
      bit          we;
      logic [31:0] addr;
      logic [31:0] seed;
      int          exp_ack;
      int          exp_en;
   } vec_t;

   vec_t vecs [8];

   initial begin
      for (int i = 0; i < 1024; i++) model_mem[i] = 32'(i);
      last_line  = '0;
      buf_valid  = 1'b0;
      buf_tag    = '0;
      vecs[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         RD_ACK,  8};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_0040, 32'h1111_0000, 9,       8};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         HIT_ACK, HIT_EN8};
      vecs[3] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,         RD_ACK,  8};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_00A0, 32'h0,         RD_ACK,  8};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_00A0, 32'h0,         HIT_ACK, HIT_EN8};
      vecs[6] = '{1'b1, 1'b1, 32'h0000_0200, 32'h2222_0000, 9,       8};
      vecs[7] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         RD_ACK,  8};

      rst        = 1'b1;
      mem_addr_i = '0;
      mem_data_i = '0;
      mem_rd_i   = 1'b0;
      mem_we_i   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_outputs_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset asserted in cycle 4 of a read.
      mem_addr_i = 32'h0000_0100;
      mem_rd_i   = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk);
         #1;
      end
      chk("midread_en_before", 256'(ram_en_o), 256'(1));
      rst = 1'b1;
      #1;
      chk_outputs_zero("midreset");
      mem_rd_i = 1'b0;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      buf_valid = 1'b0;
      last_line = '0;
      do_op(1'b1, 1'b0, 32'h0000_0100, '0, -1, RD_ACK, 8);

      // Directed table from the test plan.
      for (int i = 0; i < 8; i++)
         do_op(vecs[i].rd, vecs[i].we, vecs[i].addr, line_of(vecs[i].seed), -1,
               vecs[i].exp_ack, vecs[i].exp_en);

      // Inputs changed in cycle 3 of a write must not affect the RAM.
      do_op(1'b0, 1'b1, 32'h0000_0300, line_of(32'h3333_0000), 3, 9, 8);
      do_op(1'b1, 1'b0, 32'h0000_0300, '0, -1, RD_ACK, 8);

      // Randomized traffic over a few lines, including tag-only aliases (bit 31).
      for (int n = 0; n < 40; n++) begin
         int           op;
         bit           rd;
         bit           we;
         bit           hit;
         logic [31:0]  addr;
         logic [255:0] wd;
         op   = int'($urandom_range(0, 3));
         rd   = (op != 2);
         we   = (op >= 2);
         addr = 32'h0000_0400 + 32'($urandom_range(0, 5)) * 32'd32;
         addr[31] = 1'($urandom_range(0, 1));
         addr[4:0] = 5'($urandom_range(0, 31));
         for (int k = 0; k < 8; k++) wd[32*k +: 32] = $urandom;
         hit = predict_hit(rd, we, addr);
         do_op(rd, we, addr, wd, -1, we ? 9 : (hit ? 1 : RD_ACK), hit ? 0 : 8);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
